sipo_rx: RTL and testbench

Serial-to-parallel receiver. It is the receiving end of the LSB-first serial stream produced by the team's 4-bit load/shift register, where q[0] is shifted out first and a right shift is applied on each sh. Bits qualified by ser_vld are assembled into W-bit words, framed by a start strobe. Completed words are handed to a downstream consumer through a registered valid/ready output stage, so reception of the next word can overlap a pending word.

---
 rtl/sipo_rx.sv | 144 ++++++++++++++
 tb/tb_sipo_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: LSB-first framed bits into W-bit words with a valid/ready output stage.
// Define SIPO_RX_PARITY_EN to expect an even-parity bit after each word.
module sipo_rx #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         ser_in,
  input  logic         ser_vld,
  input  logic         frm,
  output logic [W-1:0] out_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic         busy,
  output logic         ovf,
  output logic         frm_err,
  output logic         par_err,
  input  logic         err_clr
);

  localparam int unsigned CW = $clog2(W + 1);

`ifdef SIPO_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1} state_t;
`endif

  state_t         state, state_nxt;
  logic [W-1:0]   sr, sr_nxt, shifted, word_c;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           done_c;
  logic           frm_set;
`ifdef SIPO_RX_PARITY_EN
  logic           par_set;
`endif

  assign shifted = {ser_in, sr[W-1:1]};

  // Next-state and receive-path decode; only accepted bits move anything
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    done_c    = 1'b0;
    word_c    = sr;
    frm_set   = 1'b0;
`ifdef SIPO_RX_PARITY_EN
    par_set   = 1'b0;
`endif
    if (ser_vld) begin
      case (state)
        IDLE: begin
          if (frm) begin
            sr_nxt    = shifted;
            cnt_nxt   = CW'(1);
            state_nxt = RECV;
          end
        end
        RECV: begin
          sr_nxt = shifted;
          if (frm) begin
            frm_set = 1'b1;
            cnt_nxt = CW'(1);
          end else if (cnt == CW'(W - 1)) begin
            cnt_nxt = '0;
`ifdef SIPO_RX_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = IDLE;
            done_c    = 1'b1;
            word_c    = shifted;
`endif
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
`ifdef SIPO_RX_PARITY_EN
        PAR: begin
          if (frm) begin
            sr_nxt    = shifted;
            cnt_nxt   = CW'(1);
            frm_set   = 1'b1;
            state_nxt = RECV;
          end else begin
            state_nxt = IDLE;
            if (^{sr, ser_in}) par_set = 1'b1;
            else               done_c  = 1'b1;
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Output stage: a completed word loads when empty or drained this same cycle
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_data <= '0;
      out_vld  <= 1'b0;
    end else if (done_c && (!out_vld || out_rdy)) begin
      out_data <= word_c;
      out_vld  <= 1'b1;
    end else if (out_vld && out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

  // Sticky flags; a set event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ovf     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      ovf     <= (ovf & ~err_clr) | (done_c & out_vld & ~out_rdy);
      frm_err <= (frm_err & ~err_clr) | frm_set;
    end
  end

`ifdef SIPO_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) par_err <= 1'b0;
    else        par_err <= (par_err & ~err_clr) | par_set;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Directed self-checking bench for sipo_rx (W=4); covers both SIPO_RX_PARITY_EN builds.
module tb_sipo_rx;

  logic       clk = 1'b0;
  logic       rst_b, ser_in, ser_vld, frm, out_rdy, err_clr;
  logic [3:0] out_data;
  logic       out_vld, busy, ovf, frm_err, par_err;

  int errors = 0;
  int checks = 0;

  sipo_rx #(.W(4)) dut (
    .clk(clk), .rst_b(rst_b), .ser_in(ser_in), .ser_vld(ser_vld), .frm(frm),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .busy(busy),
    .ovf(ovf), .frm_err(frm_err), .par_err(par_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic f);
    ser_vld = 1'b1;
    ser_in  = b;
    frm     = f;
    @(posedge clk);
    #1;
    ser_vld = 1'b0;
    ser_in  = 1'b0;
    frm     = 1'b0;
  endtask

  // Framed word, plus correct parity bit when enabled; err_clr/out_rdy optionally raised on the final bit
  task automatic send_word(input logic [3:0] d, input logic clr_last, input logic rdy_last);
    for (int i = 0; i < 4; i++) begin
`ifndef SIPO_RX_PARITY_EN
      if (i == 3) begin
        err_clr = clr_last;
        if (rdy_last) out_rdy = 1'b1;
      end
`endif
      send_bit(d[i], i == 0);
    end
`ifdef SIPO_RX_PARITY_EN
    err_clr = clr_last;
    if (rdy_last) out_rdy = 1'b1;
    send_bit(^d, 1'b0);
`endif
    err_clr = 1'b0;
    if (rdy_last) out_rdy = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0; ser_in = 1'b0; ser_vld = 1'b0; frm = 1'b0;
    out_rdy = 1'b0; err_clr = 1'b0;
    tick(2);
    chk("rst_vld", out_vld, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_frm_err", frm_err, 0);
    chk("rst_par_err", par_err, 0);
    rst_b = 1'b1;
    tick(1);

    // Basic word 1,1,0,1 -> 4'b1011
    out_rdy = 1'b1;
    send_bit(1'b1, 1'b1);
    chk("basic_busy_b0", busy, 1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("basic_busy_b2", busy, 1);
    chk("basic_vld_early", out_vld, 0);
    send_bit(1'b1, 1'b0);
`ifdef SIPO_RX_PARITY_EN
    chk("basic_busy_par", busy, 1);
    chk("basic_vld_par", out_vld, 0);
    send_bit(1'b1, 1'b0);
`endif
    chk("basic_vld", out_vld, 1);
    chk("basic_data", out_data, 4'b1011);
    chk("basic_busy_done", busy, 0);
    tick(1);
    chk("basic_vld_drop", out_vld, 0);

    // Same word with ser_vld gaps
    send_bit(1'b1, 1'b1);
    tick(2);
    send_bit(1'b1, 1'b0);
    tick(1);
    send_bit(1'b0, 1'b0);
    tick(3);
    chk("gap_busy", busy, 1);
    send_bit(1'b1, 1'b0);
`ifdef SIPO_RX_PARITY_EN
    tick(2);
    send_bit(1'b1, 1'b0);
`endif
    chk("gap_vld", out_vld, 1);
    chk("gap_data", out_data, 4'b1011);
    tick(1);

    // Unframed bits in IDLE are ignored
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("ign_busy", busy, 0);
    chk("ign_vld", out_vld, 0);
    chk("ign_frm_err", frm_err, 0);

    // Overflow: second word dropped while the first is held
    out_rdy = 1'b0;
    send_word(4'b0011, 1'b0, 1'b0);
    chk("ovf_first_vld", out_vld, 1);
    chk("ovf_first_data", out_data, 4'b0011);
    send_word(4'b1100, 1'b0, 1'b0);
    chk("ovf_held_data", out_data, 4'b0011);
    chk("ovf_set", ovf, 1);
    out_rdy = 1'b1;
    tick(1);
    chk("ovf_drain_vld", out_vld, 0);
    out_rdy = 1'b0;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("ovf_clr", ovf, 0);

    // Overflow coinciding with err_clr keeps the flag
    send_word(4'b0011, 1'b0, 1'b0);
    send_word(4'b1100, 1'b1, 1'b0);
    chk("ovf_clr_race", ovf, 1);
    chk("ovf_race_data", out_data, 4'b0011);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("ovf_clr2", ovf, 0);

    // Drain and load in the same cycle
    send_word(4'b0101, 1'b0, 1'b1);
    chk("dl_vld", out_vld, 1);
    chk("dl_data", out_data, 4'b0101);
    chk("dl_ovf", ovf, 0);
    out_rdy = 1'b1;
    tick(1);
    chk("dl_drain", out_vld, 0);

    // Frame error: restart after two bits, then 0,1,1 -> 4'b1101
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    chk("fe_none_yet", frm_err, 0);
    send_bit(1'b1, 1'b1);
    chk("fe_set", frm_err, 1);
    chk("fe_busy", busy, 1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
`ifdef SIPO_RX_PARITY_EN
    send_bit(1'b1, 1'b0);
`endif
    chk("fe_vld", out_vld, 1);
    chk("fe_data", out_data, 4'b1101);
    tick(1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("fe_clr", frm_err, 0);

`ifdef SIPO_RX_PARITY_EN
    // Bad parity: 4'b1011 with parity 0 is dropped
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("par_bad_vld", out_vld, 0);
    chk("par_bad_err", par_err, 1);
    chk("par_bad_busy", busy, 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("par_clr", par_err, 0);
`else
    chk("par_tied", par_err, 0);
`endif

    // Asynchronous reset mid-word with a held word and ovf pending
    out_rdy = 1'b0;
    send_word(4'b1001, 1'b0, 1'b0);
    send_word(4'b1001, 1'b0, 1'b0);
    chk("mr_pre_ovf", ovf, 1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("mr_pre_busy", busy, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("mr_vld", out_vld, 0);
    chk("mr_data", out_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ovf", ovf, 0);
    #2 rst_b = 1'b1;
    tick(1);
    send_word(4'b0110, 1'b0, 1'b0);
    chk("mr_word_vld", out_vld, 1);
    chk("mr_word_data", out_data, 4'b0110);
    chk("mr_word_ovf", ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
